// File: rtl/puf_mux_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : puf_mux_scanner
//  Purpose  : Walks a registered select across N_IN PUF response cells under
//             a per-challenge enable mask. Each enabled cell gets a settle
//             delay followed by SAMPLES-way majority voting. The voted bits
//             are assembled into a response word with a start/done handshake.
//  Ports    : clk          - system clock, rising edge
//             rst          - synchronous active-high reset
//             start        - scan request, accepted only when idle
//             enable_mask  - per-cell include mask, latched on accepted start
//             d_in         - raw PUF cell outputs, observed only while sampling
//             sel_out      - current cell index (registered)
//             busy         - high while a scan is in progress
//             done         - one-cycle pulse at scan completion
//             response     - voted response word, masked cells read 0
//             resp_mask    - enable mask belonging to response
//  Revision : 1.0 - initial release
// ============================================================================
module puf_mux_scanner #(
    parameter int N_IN    = 16,
    parameter int SETTLE  = 2,
    parameter int SAMPLES = 3,
    localparam int SEL_W  = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_IN-1:0]  enable_mask,
    input  logic [N_IN-1:0]  d_in,
    output logic [SEL_W-1:0] sel_out,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  response,
    output logic [N_IN-1:0]  resp_mask
);

    // One shared counter serves both the settle and the sample phases.
    localparam int CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ONES_W  = $clog2(SAMPLES + 1);

    localparam logic [CNT_W-1:0]  c_SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  c_SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE     = CNT_W'(1);
    localparam logic [ONES_W-1:0] c_ONES_ONE    = ONES_W'(1);
    localparam logic [ONES_W-1:0] c_VOTE_THR    = ONES_W'(SAMPLES / 2);
    localparam logic [SEL_W-1:0]  c_SEL_LAST    = SEL_W'(N_IN - 1);
    localparam logic [SEL_W-1:0]  c_SEL_ONE     = SEL_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETTLE = 3'd1;
    localparam logic [2:0] c_ST_SAMPLE = 3'd2;
    localparam logic [2:0] c_ST_WRITE  = 3'd3;
    localparam logic [2:0] c_ST_SKIP   = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ONES_W-1:0] r_ones;
    logic [SEL_W-1:0]  r_sel;
    logic [N_IN-1:0]   r_mask;
    logic [N_IN-1:0]   r_response;
    logic [N_IN-1:0]   r_resp_mask;
    logic              r_busy;
    logic              r_done;

    logic [SEL_W-1:0]  w_sel_inc;
    logic              w_last;

    // w_sel_inc may wrap or exceed N_IN-1 on the last cell; it is only
    // consumed when w_last is low, so unused select codes are never driven.
    assign w_sel_inc = r_sel + c_SEL_ONE;
    assign w_last    = (r_sel == c_SEL_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = enable_mask[0] ? c_ST_SETTLE : c_ST_SKIP;
                end
            end
            c_ST_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_SAMPLE: begin
                if (r_cnt == c_SAMPLE_LAST) begin
                    w_state_nxt = c_ST_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_WRITE, c_ST_SKIP: begin
                if (w_last) begin
                    w_state_nxt = c_ST_DONE;
                end else if (r_mask[w_sel_inc]) begin
                    w_state_nxt = c_ST_SETTLE;
                end else begin
                    w_state_nxt = c_ST_SKIP;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_ones      <= '0;
            r_sel       <= '0;
            r_mask      <= '0;
            r_response  <= '0;
            r_resp_mask <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mask     <= enable_mask;
                        r_response <= '0;
                        r_sel      <= '0;
                        r_ones     <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                c_ST_SAMPLE: begin
                    if (d_in[r_sel]) begin
                        r_ones <= r_ones + c_ONES_ONE;
                    end
                end
                c_ST_WRITE, c_ST_SKIP: begin
                    if (r_state == c_ST_WRITE) begin
                        r_response[r_sel] <= (r_ones > c_VOTE_THR);
                        r_ones            <= '0;
                    end
                    // done, busy and resp_mask all change on the edge into
                    // DONE so they line up with the final response bit.
                    if (w_last) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_resp_mask <= r_mask;
                    end else begin
                        r_sel <= w_sel_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_out   = r_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign response  = r_response;
    assign resp_mask = r_resp_mask;

endmodule
`default_nettype wire

// File: doc/puf_mux_scanner.md
Name: puf_mux_scanner

Overview:
Parametrised successor to the fixed 16-to-1 select mux used to read PUF cell outputs. It walks a registered select across N_IN response cells under a per-challenge enable mask. Each enabled cell gets a settle delay and majority-vote sampling, and the results are assembled into a response word with a start/done handshake. It sits between the PUF cell array and the response/key-extraction logic.

Parameters:
N_IN, 16, number of PUF cell inputs (>=2)
SEL_W, $clog2(N_IN), select width (derived, not overridden)
SETTLE, 2, cycles waited after a select change before sampling (>=1)
SAMPLES, 3, samples per cell for majority vote (odd, >=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a scan; accepted only in IDLE
enable_mask  in  N_IN  per-cell include mask, latched on accepted start
d_in  in  N_IN  raw PUF cell outputs (asynchronous to scan, treated as data)
sel_out  out  SEL_W  current cell index (registered), drives external mux/cell enable
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse at scan completion
response  out  N_IN  voted response; bit i = majority of d_in[i] samples, 0 if masked
resp_mask  out  N_IN  copy of the latched enable_mask belonging to response

Behaviour:
- Reset (rst=1 at an edge): state IDLE; sel_out=0, busy=0, done=0, response=0, resp_mask=0, all counters 0. Reset mid-scan aborts immediately with no done pulse.
- States: IDLE, SETTLE, SAMPLE, WRITE, SKIP, DONE.
- IDLE: a start=1 at edge k latches enable_mask, clears response, sets sel_out=0 and busy=1 from cycle k+1. The next state is SETTLE if mask[0]=1, else SKIP.
- SETTLE: wait SETTLE cycles; no sampling.
- SAMPLE: SAMPLES cycles. Each cycle registers d_in[sel_out] and increments ones_cnt (width $clog2(SAMPLES+1)) when the bit is 1.
- WRITE: 1 cycle. response[sel_out] <= (ones_cnt > SAMPLES/2); ones_cnt cleared.
- SKIP: 1 cycle. response[sel_out] stays 0.
- Index advance after WRITE/SKIP: if sel_out==N_IN-1, go to DONE. Otherwise sel_out+1, then SETTLE if that cell's mask bit is 1, else SKIP. No wrap past N_IN-1. Unused select codes (N_IN not a power of 2) are never driven.
- DONE: 1 cycle. done=1, busy=0, resp_mask updated, then IDLE.
- Enabled cell cost = SETTLE+SAMPLES+1 cycles; masked cell cost = 1 cycle.
- Timing: start accepted at edge k gives done high in cycle k+1+sum(cell costs).
- Defaults, full mask: 16*6=96 busy cycles, done at k+97.
- start while busy or in DONE: ignored (not queued). start in the cycle after DONE (IDLE) is accepted.
- response and resp_mask hold the last completed scan until the next accepted start. response clears on start; resp_mask changes only at DONE.
- enable_mask and d_in changes during a scan: the mask is not re-read. d_in is only observed in SAMPLE cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Defaults, full mask 0xFFFF, d_in=0xAAAA static, pulse start -> busy for 96 cycles, done single pulse at start+97, response=0xAAAA, resp_mask=0xFFFF, sel_out steps 0..15 every 6 cycles.
- Mask 0x000F, d_in=0xFFFF -> response=0x000F, done at start+(4*6+12)+1=start+37, sel_out visits 4..15 one cycle each.
- Majority: cell 5 with d_in[5]=1 except 0 on one SAMPLE cycle -> response[5]=1. 0 on two of three SAMPLE cycles -> response[5]=0.
- Mask 0x0000 -> done at start+17, response=0x0000. start re-asserted at cycle start+5 -> ignored, exactly one done pulse.
- rst asserted at start+40 for 1 cycle -> next cycle busy=0, done=0, sel_out=0, response=0, no done pulse afterwards. A new start then completes normally.
- Parameter sweep N_IN=5, SETTLE=1, SAMPLES=1, full mask, d_in=5'b10110 -> response=5'b10110, done at start+5*3+1=start+16, sel_out never exceeds 4.
